key_expand256: RTL and testbench

KEY_EXPAND256 -- requirements
Module: key_expand256

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_sbox.sv | 47 ++++
 rtl/key_expand256.sv | 122 ++++++++++++
 tb/tb_key_expand256.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
// Shared constants and types for the AES-256 key expansion block.
//   NK, NR, NUM_WORDS : AES-256 key/round geometry (8 key words, 14 rounds, 60 words)
//   RCON_TABLE        : round constants packed one byte per index, index 0 unused
//   state_t           : key expansion FSM states
//   rcon()            : returns the round constant for a given i/8 index
package aes_pkg;

  localparam int NK        = 8;
  localparam int NR        = 14;
  localparam int NUM_WORDS = 4 * (NR + 1);

  // Byte k holds Rcon[k]; AES-256 only ever needs indices 1..7.
  localparam logic [63:0] RCON_TABLE = {8'h40, 8'h20, 8'h10, 8'h08,
                                        8'h04, 8'h02, 8'h01, 8'h00};

  typedef enum logic [2:0] {
    IDLE,
    LOAD0,
    LOAD1,
    EXPAND,
    FINISH
  } state_t;

  function automatic logic [7:0] rcon(input logic [2:0] idx);
    return RCON_TABLE[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox
// Combinational FIPS-197 S-box: multiplicative inverse in GF(2^8) followed
// by the affine transform.
//   in_byte  : input byte
//   out_byte : substituted byte
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (a^-1 in the field, and 0 maps to 0 naturally):
  // accumulates a^2 * a^4 * ... * a^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  // Affine step expressed as xor of left rotations plus the 0x63 constant.
  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/key_expand256.sv
// key_expand256
// AES-256 key expansion producing the 15 round keys in ascending order,
// one expanded word per cycle from a sliding 8-word window.
//   clk, resetn : clock, asynchronous active-low reset
//   start       : begin expansion of key_in (only honoured in IDLE)
//   key_in      : 256-bit cipher key, w0 in the top word
//   busy        : expansion in progress
//   done        : one-cycle pulse after round key 14 is written
//   rk_wr_en    : round-key store write strobe
//   rk_addr     : round index being written (0..14)
//   rk_data     : round key, lowest-index word in the top 32 bits
module key_expand256
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [255:0]          key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  rk_wr_en,
  output logic [ADDR_WIDTH-1:0] rk_addr,
  output logic [DATA_WIDTH-1:0] rk_data
);

  state_t       state;
  // window[255:224] is w(i-8), window[31:0] is w(i-1) for the word being made.
  logic [255:0] window;
  logic [5:0]   word_idx;

  logic [31:0]  temp;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp_mixed;
  logic [31:0]  new_word;

  // Word path: RotWord only on i%8==0, so the S-box input is muxed ahead of
  // the shared four S-boxes; i%8==4 uses SubWord without rotation.
  always_comb begin
    temp       = window[31:0];
    sub_in     = (word_idx[2:0] == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    temp_mixed = temp;
    if (word_idx[2:0] == 3'd0) begin
      temp_mixed = sub_out ^ {rcon(word_idx[5:3]), 24'h000000};
    end else if (word_idx[2:0] == 3'd4) begin
      temp_mixed = sub_out;
    end
    new_word = window[255:224] ^ temp_mixed;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  // Control FSM with registered outputs. The two key halves are emitted
  // directly as round keys 0 and 1; afterwards a round key is complete every
  // fourth word (i%4==3) and is written in the cycle that word is registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      window   <= '0;
      word_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_wr_en <= 1'b0;
      rk_addr  <= '0;
      rk_data  <= '0;
    end else begin
      rk_wr_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            window <= key_in;
            busy   <= 1'b1;
            state  <= LOAD0;
          end
        end
        LOAD0: begin
          rk_wr_en <= 1'b1;
          rk_addr  <= ADDR_WIDTH'(4'd0);
          rk_data  <= DATA_WIDTH'(window[255:128]);
          state    <= LOAD1;
        end
        LOAD1: begin
          rk_wr_en <= 1'b1;
          rk_addr  <= ADDR_WIDTH'(4'd1);
          rk_data  <= DATA_WIDTH'(window[127:0]);
          word_idx <= 6'(NK);
          state    <= EXPAND;
        end
        EXPAND: begin
          window <= {window[223:0], new_word};
          if (word_idx[1:0] == 2'd3) begin
            rk_wr_en <= 1'b1;
            rk_addr  <= ADDR_WIDTH'(word_idx[5:2]);
            rk_data  <= DATA_WIDTH'({window[95:0], new_word});
          end
          if (word_idx == 6'(NUM_WORDS - 1)) begin
            word_idx <= '0;
            state    <= FINISH;
          end else begin
            word_idx <= word_idx + 6'd1;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand256.sv
// tb_key_expand256
// Self-checking bench for key_expand256: known-answer vectors, cycle timing,
// ignored restart, reset abort, back-to-back and random keys against a
// behavioural key schedule built from the FIPS-197 word rule.
module tb_key_expand256;

  localparam int DW = 128;
  localparam int AW = 4;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [255:0]  key_in;
  logic          busy;
  logic          done;
  logic          rk_wr_en;
  logic [AW-1:0] rk_addr;
  logic [DW-1:0] rk_data;

  key_expand256 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .rk_wr_en (rk_wr_en),
    .rk_addr  (rk_addr),
    .rk_data  (rk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int n0    = 0;

  logic [AW-1:0] wq_addr [$];
  logic [DW-1:0] wq_data [$];
  int            wq_cyc  [$];
  int            dq_cyc  [$];

  logic [7:0]    sbox_tab [256];
  logic [127:0]  exp_rk   [15];

  // Record every write and done pulse, stamped with the edge count.
  always @(negedge clk) begin
    if (rk_wr_en) begin
      wq_addr.push_back(rk_addr);
      wq_data.push_back(rk_data);
      wq_cyc.push_back(cyc);
    end
    if (done) dq_cyc.push_back(cyc);
  end

  // Carry-less product then polynomial reduction by 0x11b.
  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // S-box table from brute-force inverse search and the bitwise affine rule.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (tb_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[a] = s;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic compute_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) t = subword({t[23:0], t[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4) t = subword(t);
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
    return k;
  endfunction

  function automatic int exp_cycle(input int a);
    return (a == 0) ? 1 : (a == 1) ? 2 : 4 * a - 2;
  endfunction

  task automatic clear_queues();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    dq_cyc.delete();
  endtask

  // Present key with start for one edge; n0 is the accepting edge N.
  task automatic begin_start(input logic [255:0] key);
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    @(negedge clk);
    n0    = cyc;
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b1;
    key_in = rand_key();
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    total++; if (rk_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en: got %b want 0", rk_wr_en); end
    total++; if (rk_addr !== '0) begin bad++; $display("[TB] FAIL reset_addr: got %0h want 0", rk_addr); end
    total++; if (rk_data !== '0) begin bad++; $display("[TB] FAIL reset_data: got %0h want 0", rk_data); end
    start  = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || rk_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_idle: busy=%b wr_en=%b want 0 0", busy, rk_wr_en); end
  endtask

  task automatic test_known_vectors();
    logic [127:0] kat1 [4];
    int           kidx [4];
    kat1[0] = 128'h603deb1015ca71be2b73aef0857d7781; kidx[0] = 0;
    kat1[1] = 128'h1f352c073b6108d72d9810a30914dff4; kidx[1] = 1;
    kat1[2] = 128'h9ba354118e6925afa51a8b5f2067fcde; kidx[2] = 2;
    kat1[3] = 128'hfe4890d1e6188d0b046df344706c631e; kidx[3] = 14;
    clear_queues();
    begin_start(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    repeat (58) @(negedge clk);
    total++; if (wq_data.size() != 15) begin bad++; $display("[TB] FAIL kat1_count: got %0d want 15", wq_data.size()); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (wq_data.size() <= kidx[j] || wq_data[kidx[j]] !== kat1[j]) begin
        bad++; $display("[TB] FAIL kat1_rk%0d: got %0h want %0h", kidx[j], (wq_data.size() > kidx[j]) ? wq_data[kidx[j]] : 128'h0, kat1[j]);
      end
    end
    kat1[0] = 128'h0; kat1[1] = 128'h0;
    kat1[2] = 128'h62636363626363636263636362636363;
    kat1[3] = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;
    clear_queues();
    begin_start(256'h0);
    repeat (58) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (wq_data.size() <= j || wq_data[j] !== kat1[j]) begin
        bad++; $display("[TB] FAIL kat0_rk%0d: got %0h want %0h", j, (wq_data.size() > j) ? wq_data[j] : 128'h0, kat1[j]);
      end
    end
  endtask

  task automatic test_timing();
    logic [255:0] key;
    logic         exp_wr;
    int           cur;
    key = rand_key();
    compute_model(key);
    clear_queues();
    begin_start(key);
    total++; if (busy !== 1'b1 || rk_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL timing_k0: busy=%b wr_en=%b want 1 0", busy, rk_wr_en); end
    cur = 0;
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      exp_wr = (k == 1) || (k == 2) || (k >= 6 && k <= 54 && (k - 6) % 4 == 0);
      if (exp_wr) cur = (k == 1) ? 0 : (k == 2) ? 1 : (k + 2) / 4;
      total++; if (busy !== (k <= 54)) begin bad++; $display("[TB] FAIL timing_busy k=%0d: got %b want %b", k, busy, (k <= 54)); end
      total++; if (done !== (k == 55)) begin bad++; $display("[TB] FAIL timing_done k=%0d: got %b want %b", k, done, (k == 55)); end
      total++; if (rk_wr_en !== exp_wr) begin bad++; $display("[TB] FAIL timing_wr_en k=%0d: got %b want %b", k, rk_wr_en, exp_wr); end
      total++; if (rk_data !== exp_rk[cur]) begin bad++; $display("[TB] FAIL timing_data k=%0d: got %0h want %0h", k, rk_data, exp_rk[cur]); end
      if (exp_wr) begin
        total++; if (rk_addr !== AW'(cur)) begin bad++; $display("[TB] FAIL timing_addr k=%0d: got %0d want %0d", k, rk_addr, cur); end
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [255:0] key_a;
    logic [255:0] key_b;
    key_a = rand_key();
    key_b = ~key_a;
    compute_model(key_a);
    clear_queues();
    begin_start(key_a);
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      if (k == 19) begin start = 1'b1; key_in = key_b; end
      if (k == 20) start = 1'b0;
    end
    total++; if (wq_data.size() != 15) begin bad++; $display("[TB] FAIL ignore_count: got %0d want 15", wq_data.size()); end
    for (int j = 0; j < 15 && j < wq_data.size(); j++) begin
      total++;
      if (wq_data[j] !== exp_rk[j] || wq_addr[j] !== AW'(j) || wq_cyc[j] != n0 + exp_cycle(j)) begin
        bad++; $display("[TB] FAIL ignore_rk%0d: got addr=%0d data=%0h cyc=%0d want addr=%0d data=%0h cyc=%0d",
                        j, wq_addr[j], wq_data[j], wq_cyc[j] - n0, j, exp_rk[j], exp_cycle(j));
      end
    end
    total++; if (dq_cyc.size() != 1 || dq_cyc[0] != n0 + 55) begin bad++; $display("[TB] FAIL ignore_done: got count=%0d want one pulse at +55", dq_cyc.size()); end
  endtask

  task automatic test_reset_abort();
    logic [255:0] key;
    clear_queues();
    begin_start(rand_key());
    repeat (30) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    total++; if (rk_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL abort_wr_en: got %b want 0", rk_wr_en); end
    total++; if (rk_data !== '0 || rk_addr !== '0) begin bad++; $display("[TB] FAIL abort_rk: got addr=%0d data=%0h want 0 0", rk_addr, rk_data); end
    total++; if (wq_data.size() != 9) begin bad++; $display("[TB] FAIL abort_pre_writes: got %0d want 9", wq_data.size()); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (wq_data.size() != 9 || dq_cyc.size() != 0) begin bad++; $display("[TB] FAIL abort_no_more: got writes=%0d dones=%0d want 9 0", wq_data.size(), dq_cyc.size()); end
    key = rand_key();
    compute_model(key);
    clear_queues();
    begin_start(key);
    repeat (58) @(negedge clk);
    total++; if (wq_data.size() != 15 || dq_cyc.size() != 1) begin bad++; $display("[TB] FAIL abort_restart_count: got writes=%0d dones=%0d want 15 1", wq_data.size(), dq_cyc.size()); end
    for (int j = 0; j < 15 && j < wq_data.size(); j++) begin
      total++;
      if (wq_data[j] !== exp_rk[j] || wq_addr[j] !== AW'(j)) begin
        bad++; $display("[TB] FAIL abort_restart_rk%0d: got addr=%0d data=%0h want addr=%0d data=%0h", j, wq_addr[j], wq_data[j], j, exp_rk[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] key_a;
    logic [255:0] key_b;
    int           base;
    key_a = rand_key();
    key_b = rand_key();
    clear_queues();
    @(negedge clk);
    key_in = key_a;
    start  = 1'b1;
    @(negedge clk);
    n0     = cyc;
    key_in = key_b;
    repeat (110) @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (wq_data.size() != 30) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 30", wq_data.size()); end
    total++; if (dq_cyc.size() != 2 || dq_cyc[0] != n0 + 55 || dq_cyc[1] != n0 + 111) begin
      bad++; $display("[TB] FAIL b2b_done: got count=%0d first=%0d second=%0d want 2 55 111", dq_cyc.size(),
                      (dq_cyc.size() > 0) ? dq_cyc[0] - n0 : -1, (dq_cyc.size() > 1) ? dq_cyc[1] - n0 : -1);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: busy got %b want 0", busy); end
    for (int half = 0; half < 2; half++) begin
      compute_model(half == 0 ? key_a : key_b);
      base = (half == 0) ? 0 : 56;
      for (int r = 0; r < 15; r++) begin
        if (15 * half + r < wq_data.size()) begin
          total++;
          if (wq_data[15*half+r] !== exp_rk[r] || wq_addr[15*half+r] !== AW'(r) || wq_cyc[15*half+r] != n0 + base + exp_cycle(r)) begin
            bad++; $display("[TB] FAIL b2b_run%0d_rk%0d: got addr=%0d data=%0h cyc=%0d want addr=%0d data=%0h cyc=%0d", half, r,
                            wq_addr[15*half+r], wq_data[15*half+r], wq_cyc[15*half+r] - n0, r, exp_rk[r], base + exp_cycle(r));
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] key;
    for (int t = 0; t < 3; t++) begin
      key = rand_key();
      compute_model(key);
      clear_queues();
      begin_start(key);
      repeat (58) @(negedge clk);
      total++; if (wq_data.size() != 15) begin bad++; $display("[TB] FAIL random%0d_count: got %0d want 15", t, wq_data.size()); end
      for (int j = 0; j < 15 && j < wq_data.size(); j++) begin
        total++;
        if (wq_data[j] !== exp_rk[j] || wq_addr[j] !== AW'(j)) begin
          bad++; $display("[TB] FAIL random%0d_rk%0d: got addr=%0d data=%0h want addr=%0d data=%0h", t, j, wq_addr[j], wq_data[j], j, exp_rk[j]);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    key_in = '0;
    build_sbox();
    $display("[TB] starting key_expand256 bench");
    test_reset();
    test_known_vectors();
    test_timing();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
